// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display controller.
//   state_t    - controller states (IDLE, CONVERT, FORMAT)
//   SEG_*      - special segment patterns (active low, bit 0 = a ... bit 6 = g)
//   SEG_TABLE  - 16-entry hex digit code table, entry i at SEG_TABLE[i]
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FORMAT  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Packed so that SEG_TABLE[i] is the code for digit value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational 4-bit digit value to 7-segment pattern.
//   code - digit value 0..15
//   seg  - active-low segments, bit 0 = a ... bit 6 = g
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: converts a signed/unsigned value to decimal (double dabble)
// or hexadecimal and drives N_DIGITS active-low 7-segment digits.
//   clk, reset         - clock, synchronous active-high reset
//   in_valid/in_ready  - value handshake (ready only while idle)
//   in_data            - value; in_signed, in_hex, blank_en are mode bits
//   seg_out            - digit d at [7d+6:7d], digit 0 rightmost
//   overflow           - displayed value did not fit (shown as "E")
//   done               - one-cycle pulse when seg_out updates
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DATA_W   = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_signed,
    input  logic                    in_hex,
    input  logic                    blank_en,
    output logic [7*N_DIGITS-1:0]   seg_out,
    output logic                    overflow,
    output logic                    done
);

    // One spare BCD/hex digit so a value one digit too wide is still seen.
    localparam int NB    = N_DIGITS + 1;
    localparam int BCD_W = 4 * NB;
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int CNT_W = 6;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mag_q, mag_d;
    logic                   neg_q, neg_d;
    logic                   hex_q, hex_d;
    logic                   blank_q, blank_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   bcd_ovf_q, bcd_ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7*N_DIGITS-1:0]  seg_q, seg_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [BCD_W-1:0]       adj_s;
    logic [EXT_W-1:0]       mag_ext_s;
    logic [BCD_W-1:0]       digits_s;
    logic                   hi_nz_s;
    logic [4:0]             sig_s;
    logic                   fmt_ovf_s;
    logic [7*N_DIGITS-1:0]  enc_s;
    logic [7*N_DIGITS-1:0]  fmt_seg_s;

    assign in_ready = (state_q == ST_IDLE) & ~reset;
    assign seg_out  = seg_q;
    assign overflow = ovf_q;
    assign done     = done_q;

    // Double dabble add-3 correction applied before each shift.
    always_comb begin
        adj_s = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (adj_s[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = adj_s[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = adj_s[4*i +: 4];
            end
        end
    end

    // Select digit source, count significant digits and detect overflow.
    always_comb begin
        mag_ext_s = EXT_W'(mag_q);
        digits_s  = hex_q ? mag_ext_s[BCD_W-1:0] : bcd_q;
        // Non-zero content beyond the spare digit always overflows.
        hi_nz_s   = hex_q ? (|(mag_ext_s >> BCD_W)) : bcd_ovf_q;
        sig_s     = 5'd1;
        for (int i = 0; i < NB; i++) begin
            if (digits_s[4*i +: 4] != 4'd0) begin
                sig_s = 5'(i + 1);
            end else begin
                sig_s = sig_s;
            end
        end
        // Without blanking the minus still costs the top digit, so one
        // condition covers both blanking modes.
        fmt_ovf_s = hi_nz_s | ((sig_s + {4'd0, neg_q}) > 5'(N_DIGITS));
    end

    genvar gd;
    generate
        for (gd = 0; gd < N_DIGITS; gd++) begin : g_enc
            seg7_encode u_enc (
                .code (digits_s[4*gd +: 4]),
                .seg  (enc_s[7*gd +: 7])
            );
        end
    endgenerate

    // Per-digit choice between encoded digit, minus, blank and error.
    always_comb begin
        fmt_seg_s = {N_DIGITS{SEG_BLANK}};
        for (int d = 0; d < N_DIGITS; d++) begin
            if (fmt_ovf_s) begin
                fmt_seg_s[7*d +: 7] = (d == 0) ? SEG_E : SEG_BLANK;
            end else if (blank_q) begin
                if (5'(d) < sig_s) begin
                    fmt_seg_s[7*d +: 7] = enc_s[7*d +: 7];
                end else if (neg_q && (5'(d) == sig_s)) begin
                    fmt_seg_s[7*d +: 7] = SEG_MINUS;
                end else begin
                    fmt_seg_s[7*d +: 7] = SEG_BLANK;
                end
            end else if (neg_q && (d == N_DIGITS - 1)) begin
                fmt_seg_s[7*d +: 7] = SEG_MINUS;
            end else begin
                fmt_seg_s[7*d +: 7] = enc_s[7*d +: 7];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        hex_d     = hex_q;
        blank_d   = blank_q;
        bcd_d     = bcd_q;
        bcd_ovf_d = bcd_ovf_q;
        cnt_d     = cnt_q;
        seg_d     = seg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    neg_d     = in_signed & in_data[DATA_W-1];
                    // Unsigned negation keeps -2^(DATA_W-1) exact.
                    mag_d     = (in_signed & in_data[DATA_W-1]) ?
                                (~in_data + DATA_W'(1)) : in_data;
                    hex_d     = in_hex;
                    blank_d   = blank_en;
                    bcd_d     = '0;
                    bcd_ovf_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = in_hex ? ST_FORMAT : ST_CONVERT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                bcd_d     = {adj_s[BCD_W-2:0], mag_q[DATA_W-1]};
                bcd_ovf_d = bcd_ovf_q | adj_s[BCD_W-1];
                mag_d     = mag_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_FORMAT;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_FORMAT: begin
                seg_d   = fmt_seg_s;
                ovf_d   = fmt_ovf_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mag_q     <= '0;
            neg_q     <= 1'b0;
            hex_q     <= 1'b0;
            blank_q   <= 1'b0;
            bcd_q     <= '0;
            bcd_ovf_q <= 1'b0;
            cnt_q     <= '0;
            seg_q     <= {N_DIGITS{SEG_BLANK}};
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            hex_q     <= hex_d;
            blank_q   <= blank_d;
            bcd_q     <= bcd_d;
            bcd_ovf_q <= bcd_ovf_d;
            cnt_q     <= cnt_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

    localparam logic [6:0] B = 7'b1111111;
    localparam logic [6:0] M = 7'b0111111;
    localparam logic [6:0] Z = 7'b1000000;
    localparam logic [6:0] E = 7'b0000110;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_data;
    logic        in_signed;
    logic        in_hex;
    logic        blank_en;
    logic [55:0] seg_out;
    logic        overflow;
    logic        done;

    typedef struct {
        logic [55:0] seg;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [6:0] codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg_display_ctrl #(.N_DIGITS(8), .DATA_W(27)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_hex    (in_hex),
        .blank_en  (blank_en),
        .seg_out   (seg_out),
        .overflow  (overflow),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference display built with integer division, independent of BCD logic.
    function automatic void model(input logic [26:0] v, input logic sgn, input logic hx,
                                  input logic blk, output logic [55:0] seg, output logic ovf);
        longint m;
        bit     neg;
        int     base;
        int     sig;
        int     dg[12];
        neg  = sgn && v[26];
        m    = neg ? (longint'(134217728) - longint'(v)) : longint'(v);
        base = hx ? 16 : 10;
        sig  = 1;
        for (int i = 0; i < 12; i++) begin
            dg[i] = int'(m % longint'(base));
            m     = m / longint'(base);
            if (dg[i] != 0) sig = i + 1;
        end
        ovf = (sig + int'(neg)) > 8;
        for (int d = 0; d < 8; d++) begin
            if (ovf)
                seg[7*d +: 7] = (d == 0) ? E : B;
            else if (blk)
                seg[7*d +: 7] = (d < sig) ? codes[dg[d]] : ((neg && d == sig) ? M : B);
            else
                seg[7*d +: 7] = (neg && d == 7) ? M : codes[dg[d]];
        end
    endfunction

    // Offer one value, hold in_valid through the busy period, then score the result.
    // Latency is the edge number (relative to the transfer edge) at which done is sampled high.
    task automatic run_vec(input string tag, input logic [26:0] v, input logic sgn,
                           input logic hx, input logic blk,
                           input logic [55:0] eseg, input logic eovf);
        exp_t e;
        int   n;
        bit   got;
        e.seg = eseg;
        e.ovf = eovf;
        e.lat = hx ? 2 : 29;
        sb.push_back(e);
        in_data   = v;
        in_signed = sgn;
        in_hex    = hx;
        blank_en  = blk;
        in_valid  = 1'b1;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (hx) in_valid = 1'b0;
        else    in_data  = 27'h5A5A5A5;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 20) in_valid = 1'b0;
            if (done) got = 1'b1;
        end
        in_valid = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_lat"}, 64'(n + 1), 64'(e.lat));
            chk({tag, "_seg"}, 64'(seg_out), 64'(e.seg));
            chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        logic [55:0] mseg;
        logic        movf;
        logic [26:0] v;
        logic        s;
        logic        h;
        logic        b;
        bit          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 27'd0;
        in_signed = 1'b0;
        in_hex    = 1'b0;
        blank_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg",   64'(seg_out),  64'({8{B}}));
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_done",  64'(done),     64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        run_vec("dec1234", 27'd1234, 1'b0, 1'b0, 1'b1,
                {B, B, B, B, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0);
        run_vec("dec_m5", 27'h7FFFFFB, 1'b1, 1'b0, 1'b1,
                {B, B, B, B, B, B, M, 7'b0010010}, 1'b0);
        run_vec("dec_m7_noblank", 27'h7FFFFF9, 1'b1, 1'b0, 1'b0,
                {M, Z, Z, Z, Z, Z, Z, 7'b1111000}, 1'b0);
        run_vec("dec_1e8", 27'd100000000, 1'b0, 1'b0, 1'b1,
                {B, B, B, B, B, B, B, E}, 1'b1);
        run_vec("dec_zero", 27'd0, 1'b0, 1'b0, 1'b1,
                {B, B, B, B, B, B, B, Z}, 1'b0);
        run_vec("hex_abcdef", 27'h0ABCDEF, 1'b0, 1'b1, 1'b1,
                {B, B, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110},
                1'b0);

        // Abort a decimal conversion with reset at transfer edge + 10.
        in_data   = 27'd4321;
        in_signed = 1'b0;
        in_hex    = 1'b0;
        blank_en  = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_seg",   64'(seg_out),  64'({8{B}}));
        chk("abort_ovf",   64'(overflow), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", 64'(seen), 64'd0);
        chk("abort_hold",   64'(seg_out), 64'({8{B}}));

        // Boundary values scored against the reference model.
        model(27'h4000000, 1'b1, 1'b0, 1'b1, mseg, movf);
        run_vec("dec_minint", 27'h4000000, 1'b1, 1'b0, 1'b1, mseg, movf);
        model(27'h4000000, 1'b1, 1'b1, 1'b1, mseg, movf);
        run_vec("hex_minint", 27'h4000000, 1'b1, 1'b1, 1'b1, mseg, movf);
        model(27'd99999999, 1'b0, 1'b0, 1'b1, mseg, movf);
        run_vec("dec_max8", 27'd99999999, 1'b0, 1'b0, 1'b1, mseg, movf);
        model(27'h7FFFFFF, 1'b0, 1'b0, 1'b1, mseg, movf);
        run_vec("dec_allones", 27'h7FFFFFF, 1'b0, 1'b0, 1'b1, mseg, movf);
        model(27'h7FFFFFF, 1'b0, 1'b1, 1'b0, mseg, movf);
        run_vec("hex_allones", 27'h7FFFFFF, 1'b0, 1'b1, 1'b0, mseg, movf);
        v = 27'h7FFFFFF - 27'd9999998;
        model(v, 1'b1, 1'b0, 1'b0, mseg, movf);
        run_vec("dec_m9999999", v, 1'b1, 1'b0, 1'b0, mseg, movf);
        model(27'h7FFFFF0, 1'b1, 1'b1, 1'b1, mseg, movf);
        run_vec("hex_m10", 27'h7FFFFF0, 1'b1, 1'b1, 1'b1, mseg, movf);

        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 1) ? 27'($urandom_range(0, 99999999)) : 27'($urandom);
            s = 1'($urandom);
            h = 1'($urandom);
            b = 1'($urandom);
            model(v, s, h, b, mseg, movf);
            run_vec($sformatf("rnd%0d", i), v, s, h, b, mseg, movf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
